// File: rtl/pipe_wb_pkg.sv
// pipe_wb_pkg: load-size codes, register-zero constant and MEM/WB register layout
package pipe_wb_pkg;
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_BU = 3'b010;
  localparam logic [2:0] LD_H  = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic [2:0]  ldsize;
    logic [4:0]  wn;
    logic [31:0] alu;
    logic [31:0] mem;
  } wb_reg_t;
endpackage

// File: rtl/pipe_wb_if.sv
// pipe_wb_if: MEM-side inputs, decode read ports and WB forwarding outputs of the write-back stage
interface pipe_wb_if;
  logic        MEMwreg;
  logic        MEMm2reg;
  logic [2:0]  MEMldsize;
  logic [4:0]  MEMwn;
  logic [31:0] MEMaluResult;
  logic [31:0] MEMmemOut;
  logic        stall;
  logic        flush;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [31:0] qa;
  logic [31:0] qb;
  logic        WBwreg;
  logic [4:0]  WBwn;
  logic [31:0] WBresult;
  modport master (
    output MEMwreg, MEMm2reg, MEMldsize, MEMwn, MEMaluResult, MEMmemOut, stall, flush, ra, rb,
    input  qa, qb, WBwreg, WBwn, WBresult
  );
  modport slave (
    input  MEMwreg, MEMm2reg, MEMldsize, MEMwn, MEMaluResult, MEMmemOut, stall, flush, ra, rb,
    output qa, qb, WBwreg, WBwn, WBresult
  );
endinterface

// File: rtl/pipe_wb_regfile32.sv
// regfile32: 32x32 register file, one sync write, two comb reads, r0 zero; WB_BYPASS_EN adds write-through reads
module regfile32
  import pipe_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  output logic [31:0] qa_o,
  output logic [31:0] qb_o
);
  logic [31:0] rf_q [32];
  logic        wr_en;
  assign wr_en = we_i && (wa_i != REG_ZERO);
  // r0 is cleared on reset and never written, so reading it directly yields zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[wa_i] <= wd_i;
    end
  end
`ifdef WB_BYPASS_EN
  assign qa_o = (wr_en && ra_i == wa_i) ? wd_i : rf_q[ra_i];
  assign qb_o = (wr_en && rb_i == wa_i) ? wd_i : rf_q[rb_i];
`else
  assign qa_o = rf_q[ra_i];
  assign qb_o = rf_q[rb_i];
`endif
endmodule

// File: rtl/pipe_wb_stage.sv
// pipe_wb_stage: MEM/WB register, load extraction and register-file write-back
// Optional write-through read ports via WB_BYPASS_EN.
module pipe_wb_stage
  import pipe_wb_pkg::*;
(
  input  logic   clk,
  input  logic   clr,
  pipe_wb_if.slave bus
);
  wb_reg_t     wb_d, wb_q;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;
  logic [31:0] result;
  always_comb begin
    wb_d = clr ? '0 : bus.flush ? '0 : bus.stall ? wb_q :
      '{wreg: bus.MEMwreg, m2reg: bus.MEMm2reg, ldsize: bus.MEMldsize,
        wn: bus.MEMwn, alu: bus.MEMaluResult, mem: bus.MEMmemOut};
  end
  always_ff @(posedge clk) wb_q <= wb_d;
  // little-endian lane select; halfword ignores address bit 0
  always_comb begin
    byte_v = wb_q.alu[1] ? (wb_q.alu[0] ? wb_q.mem[31:24] : wb_q.mem[23:16])
                         : (wb_q.alu[0] ? wb_q.mem[15:8]  : wb_q.mem[7:0]);
    half_v = wb_q.alu[1] ? wb_q.mem[31:16] : wb_q.mem[15:0];
    load_v = (wb_q.ldsize == LD_B)  ? {{24{byte_v[7]}}, byte_v} :
             (wb_q.ldsize == LD_BU) ? {24'd0, byte_v} :
             (wb_q.ldsize == LD_H)  ? {{16{half_v[15]}}, half_v} :
             (wb_q.ldsize == LD_HU) ? {16'd0, half_v} : wb_q.mem;
    result = wb_q.m2reg ? load_v : wb_q.alu;
  end
  assign bus.WBwreg   = wb_q.wreg;
  assign bus.WBwn     = wb_q.wn;
  assign bus.WBresult = result;
  regfile32 u_rf (
    .clk  (clk),
    .rst  (clr),
    .we_i (wb_q.wreg),
    .wa_i (wb_q.wn),
    .wd_i (result),
    .ra_i (bus.ra),
    .rb_i (bus.rb),
    .qa_o (bus.qa),
    .qb_o (bus.qb)
  );
endmodule

// File: tb/tb_pipe_wb_stage.sv
// tb_pipe_wb_stage: directed vectors with hand-computed expectations for pipe_wb_stage
module tb_pipe_wb_stage;
  logic clk = 0;
  logic clr = 1;
  int n_chk = 0;
  int n_err = 0;
  pipe_wb_if bus ();
  pipe_wb_stage dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic w, input logic m2, input logic [2:0] ls, input logic [4:0] wn,
                       input logic [31:0] alu, input logic [31:0] mem);
    bus.MEMwreg = w; bus.MEMm2reg = m2; bus.MEMldsize = ls;
    bus.MEMwn = wn; bus.MEMaluResult = alu; bus.MEMmemOut = mem;
  endtask
  typedef struct {logic [2:0] ls; logic [1:0] a; logic [31:0] exp;} ld_vec_t;
  ld_vec_t lv [10] = '{
    '{3'b001, 2'd3, 32'hFFFF_FF80}, '{3'b010, 2'd2, 32'h0000_00FF},
    '{3'b011, 2'd0, 32'h0000_7F01}, '{3'b100, 2'd2, 32'h0000_80FF},
    '{3'b111, 2'd0, 32'h80FF_7F01}, '{3'b000, 2'd1, 32'h80FF_7F01},
    '{3'b011, 2'd1, 32'h0000_7F01}, '{3'b001, 2'd0, 32'h0000_0001},
    '{3'b011, 2'd2, 32'hFFFF_80FF}, '{3'b010, 2'd1, 32'h0000_007F}
  };
  initial begin
    drive(0, 0, 3'b000, 5'd0, 32'd0, 32'd0);
    bus.stall = 0; bus.flush = 0; bus.ra = 5'd5; bus.rb = 5'd31;
    step(); step();
    clr = 0;
    check("rst_qa", bus.qa, 32'd0);
    check("rst_qb", bus.qb, 32'd0);
    check("rst_wbwreg", {31'd0, bus.WBwreg}, 32'd0);
    check("rst_wbwn", {27'd0, bus.WBwn}, 32'd0);
    check("rst_wbresult", bus.WBresult, 32'd0);
    // ALU write to r3
    drive(1, 0, 3'b000, 5'd3, 32'h1234_5678, 32'h0);
    bus.ra = 5'd3;
    step();
    check("alu_wbresult", bus.WBresult, 32'h1234_5678);
    check("alu_wbwreg", {31'd0, bus.WBwreg}, 32'd1);
    check("alu_wbwn", {27'd0, bus.WBwn}, 32'd3);
    check("alu_qa_n1", bus.qa, BYP ? 32'h1234_5678 : 32'd0);
    drive(0, 0, 3'b000, 5'd0, 32'd0, 32'd0);
    step();
    check("alu_qa_n2", bus.qa, 32'h1234_5678);
    // load sizing, no register write
    foreach (lv[i]) begin
      drive(0, 1, lv[i].ls, 5'd0, {30'h0000_1000, lv[i].a}, 32'h80FF_7F01);
      step();
      check($sformatf("load%0d", i), bus.WBresult, lv[i].exp);
    end
    // load result written to r4, read on port b
    drive(1, 1, 3'b001, 5'd4, 32'h0000_0003, 32'h80FF_7F01);
    bus.rb = 5'd4;
    step();
    drive(0, 0, 3'b000, 5'd0, 32'd0, 32'd0);
    step();
    check("load_wr_qb", bus.qb, 32'hFFFF_FF80);
    // r0 never written
    drive(1, 0, 3'b000, 5'd0, 32'hDEAD_BEEF, 32'h0);
    bus.ra = 5'd0;
    step();
    check("r0_qa_n1", bus.qa, 32'd0);
    drive(0, 0, 3'b000, 5'd0, 32'd0, 32'd0);
    step();
    check("r0_qa_n2", bus.qa, 32'd0);
    // flush beats stall
    drive(1, 0, 3'b000, 5'd7, 32'hAAAA_0007, 32'h0);
    step();
    drive(0, 0, 3'b000, 5'd0, 32'd0, 32'd0);
    step();
    drive(1, 0, 3'b000, 5'd7, 32'h5555_5555, 32'h0);
    bus.flush = 1; bus.stall = 1; bus.ra = 5'd7;
    step();
    check("flush_wbwreg", {31'd0, bus.WBwreg}, 32'd0);
    bus.flush = 0; bus.stall = 0;
    drive(0, 0, 3'b000, 5'd0, 32'd0, 32'd0);
    step();
    check("flush_r7", bus.qa, 32'hAAAA_0007);
    // stall holds WB fields
    drive(1, 0, 3'b000, 5'd8, 32'h0000_0088, 32'h0);
    step();
    drive(1, 0, 3'b000, 5'd9, 32'h0000_0099, 32'h0);
    bus.stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall_wn%0d", k), {27'd0, bus.WBwn}, 32'd8);
      check($sformatf("stall_res%0d", k), bus.WBresult, 32'h0000_0088);
    end
    bus.stall = 0;
    step();
    check("unstall_wn", {27'd0, bus.WBwn}, 32'd9);
    check("unstall_res", bus.WBresult, 32'h0000_0099);
    bus.ra = 5'd8;
    drive(0, 0, 3'b000, 5'd0, 32'd0, 32'd0);
    step();
    check("stall_r8", bus.qa, 32'h0000_0088);
    bus.ra = 5'd9;
    check("stall_r9", bus.qa, 32'h0000_0099);
    // clr with an in-flight write
    drive(1, 0, 3'b000, 5'd9, 32'h0000_0012, 32'h0);
    step();
    check("pre_clr_wbwreg", {31'd0, bus.WBwreg}, 32'd1);
    clr = 1;
    step();
    clr = 0;
    drive(0, 0, 3'b000, 5'd0, 32'd0, 32'd0);
    check("clr_wbwreg", {31'd0, bus.WBwreg}, 32'd0);
    check("clr_r9", bus.qa, 32'd0);
    bus.ra = 5'd8; bus.rb = 5'd3;
    #1;
    check("clr_r8", bus.qa, 32'd0);
    check("clr_r3", bus.qb, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
